sc_microseq: RTL and testbench
==============================

SC_MICROSEQ -- requirements
Module: SC_MICROSEQ

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, and SHALL expose the ports listed in REQ-002 to REQ-012.
REQ-002 SC_MICROSEQ_CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-003 SC_MICROSEQ_RESET_InLow  in  1  synchronous, active-low reset, sampled on the rising clock edge.
REQ-004 SC_MICROSEQ_Cond_InBUS  in  3  branch condition field of the current microword (from the MIR).
REQ-005 SC_MICROSEQ_JumpAddr_InBUS  in  11  jump address field of the current microword.
REQ-006 SC_MICROSEQ_Flags_InBUS  in  4  PSR flags {n,z,v,c}, bit 3 = n.
REQ-007 SC_MICROSEQ_IR_InBUS  in  32  instruction register contents.
REQ-008 SC_MICROSEQ_Read_In / SC_MICROSEQ_Write_In  in  1 each  memory-access bits of the current microword.
REQ-009 SC_MICROSEQ_MemReady_In  in  1  memory completion strobe, active-high.
REQ-010 SC_MICROSEQ_CSAddr_OutBUS  out  11  registered control-store address.
REQ-011 SC_MICROSEQ_Stall_Out  out  1  high while the sequencer holds its address for memory.
REQ-012 SC_MICROSEQ_State_OutBUS  out  2  current FSM state encoding: BOOT=00, RUN=01, WAIT=10.

Function
REQ-013 The block SHALL hold an 11-bit CSAI register that drives SC_MICROSEQ_CSAddr_OutBUS directly, with no combinational path from any input to that output.
REQ-014 In RUN with no stall, the block SHALL load next address N on each rising edge, selected by Cond: 000 -> CSAI+1; 001 -> Jump if n else CSAI+1; 010 -> Jump if z, else CSAI+1; 011 -> Jump if v, else CSAI+1; 100 -> Jump if c, else CSAI+1; 101 -> Jump if IR[13], else CSAI+1; 110 -> Jump always; 111 -> DECODE.
REQ-015 The DECODE address SHALL be {1'b1, IR[31:30], IR[24:19], 2'b00}.
REQ-016 CSAI+1 SHALL be computed modulo 2^11, so that 2047+1 wraps to 0 with no flag raised.
REQ-017 The FSM SHALL use three states: BOOT, RUN and WAIT.
REQ-018 BOOT -> RUN SHALL occur unconditionally on the first edge after reset release; the CSAI register SHALL stay 0 on that edge, so the microword at address 0 is presented for two cycles, allowing the MIR to fill.
REQ-019 RUN -> WAIT SHALL occur when a stall condition (REQ-025) is true; the CSAI register SHALL hold its value and Stall_Out SHALL be 1 from that edge.
REQ-020 WAIT -> RUN SHALL occur on the edge where MemReady_In = 1; on that same edge the CSAI register SHALL load N, evaluated with the inputs present on that edge.
REQ-021 While in WAIT with MemReady_In = 0, the CSAI register and Stall_Out SHALL hold.
REQ-022 When Read_In and Write_In are both 1, the block SHALL treat the cycle as a single memory access; only one wait is taken.
REQ-023 In the cycle where the RUN -> WAIT transition is decided, Stall_Out SHALL be 0, since it is a registered output.
REQ-024 The flag and IR inputs SHALL be sampled only on the edge on which N is loaded.

Reset
REQ-025 The stall condition SHALL be (Read_In or Write_In) and MemReady_In = 0, in RUN, when SC_MICROSEQ_MEMWAIT_EN is defined; see REQ-030.
REQ-026 Reset_InLow = 0 at a rising edge SHALL force CSAddr = 0, Stall_Out = 0 and State = BOOT, overriding all other inputs.
REQ-027 A reset asserted during WAIT SHALL abandon the pending access; the next state SHALL be BOOT regardless of MemReady_In.
REQ-028 A reset deassertion SHALL take effect only at a clock edge; there SHALL be no asynchronous path.

Configuration
REQ-029 The optional feature SHALL be controlled by the macro SC_MICROSEQ_MEMWAIT_EN.
REQ-030 With SC_MICROSEQ_MEMWAIT_EN defined, the WAIT state and the MemReady_In handshake of REQ-019 to REQ-022 SHALL be active.
REQ-031 With SC_MICROSEQ_MEMWAIT_EN undefined, memory SHALL be treated as single-cycle: WAIT SHALL be unreachable, Stall_Out SHALL be tied to 0, and MemReady_In SHALL be ignored; the port list SHALL be unchanged.

Verification
REQ-032 Reset then release, Cond=000 -> CSAddr sequence 0,0,1,2,3 over successive edges; State sequence BOOT, RUN.
REQ-033 CSAddr=5, Cond=010, Jump=0x400, Flags=0100 -> next CSAddr=0x400; same case with Flags=0000 -> next CSAddr=6.
REQ-034 Cond=111, IR=0x8200_0000 (op=10, op3=000000) -> next CSAddr=0x600; IR=0xC000_0000 -> next CSAddr=0x700.
REQ-035 With MEMWAIT_EN defined: Read_In=1, MemReady low for 3 cycles then high, CSAddr=9, Cond=000 -> CSAddr holds 9, Stall_Out high 3 cycles, then CSAddr=10 and Stall_Out=0.
REQ-036 CSAddr=2047, Cond=000 -> next CSAddr=0; Cond=110, Jump=2047 from 2047 -> CSAddr holds 2047.
REQ-037 Reset_InLow pulsed low for one edge mid-WAIT -> CSAddr=0, State=BOOT, Stall_Out=0 on that edge.

Source files
------------

// File: rtl/sc_microseq.sv
// sc_microseq: microprogram sequencer with a registered control-store address.
// Optional memory wait state enabled by the macro SC_MICROSEQ_MEMWAIT_EN.
//
// Ports:
//   SC_MICROSEQ_CLOCK_50       in   1   system clock, rising edge
//   SC_MICROSEQ_RESET_InLow    in   1   synchronous active-low reset
//   SC_MICROSEQ_Cond_InBUS     in   3   microword branch condition
//   SC_MICROSEQ_JumpAddr_InBUS in  11   microword jump address
//   SC_MICROSEQ_Flags_InBUS    in   4   PSR flags {n,z,v,c}
//   SC_MICROSEQ_IR_InBUS       in  32   instruction register
//   SC_MICROSEQ_Read_In        in   1   microword memory read
//   SC_MICROSEQ_Write_In       in   1   microword memory write
//   SC_MICROSEQ_MemReady_In    in   1   memory completion strobe
//   SC_MICROSEQ_CSAddr_OutBUS  out 11   control-store address (registered)
//   SC_MICROSEQ_Stall_Out      out  1   address held for memory (registered)
//   SC_MICROSEQ_State_OutBUS   out  2   BOOT=00, RUN=01, WAIT=10
module sc_microseq (
    input  logic        SC_MICROSEQ_CLOCK_50,
    input  logic        SC_MICROSEQ_RESET_InLow,
    input  logic [2:0]  SC_MICROSEQ_Cond_InBUS,
    input  logic [10:0] SC_MICROSEQ_JumpAddr_InBUS,
    input  logic [3:0]  SC_MICROSEQ_Flags_InBUS,
    input  logic [31:0] SC_MICROSEQ_IR_InBUS,
    input  logic        SC_MICROSEQ_Read_In,
    input  logic        SC_MICROSEQ_Write_In,
    input  logic        SC_MICROSEQ_MemReady_In,
    output logic [10:0] SC_MICROSEQ_CSAddr_OutBUS,
    output logic        SC_MICROSEQ_Stall_Out,
    output logic [1:0]  SC_MICROSEQ_State_OutBUS
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [10:0] csai_q;
    logic [10:0] csai_d;
    logic        stall_q;
    logic        stall_d;

    logic [10:0] incr_addr;
    logic [10:0] decode_addr;
    logic [10:0] next_addr;
    logic        taken;
    logic        mem_access;
    logic        stall_cond;
    logic        unused_bits;

    // 11-bit add wraps 2047 -> 0 with no carry kept.
    assign incr_addr   = csai_q + 11'd1;
    assign decode_addr = {1'b1,
                          SC_MICROSEQ_IR_InBUS[31:30],
                          SC_MICROSEQ_IR_InBUS[24:19],
                          2'b00};

    // Read and write together are one access, so a plain OR suffices.
    assign mem_access = SC_MICROSEQ_Read_In | SC_MICROSEQ_Write_In;

`ifdef SC_MICROSEQ_MEMWAIT_EN
    assign stall_cond = mem_access & ~SC_MICROSEQ_MemReady_In;
`else
    // Single-cycle memory: never hold the address.
    assign stall_cond = 1'b0;
`endif

    assign unused_bits = ^{SC_MICROSEQ_IR_InBUS[29:25],
                           SC_MICROSEQ_IR_InBUS[18:14],
                           SC_MICROSEQ_IR_InBUS[12:0],
                           SC_MICROSEQ_MemReady_In,
                           mem_access};

    // Branch condition select.
    always_comb begin
        taken = 1'b0;
        unique case (SC_MICROSEQ_Cond_InBUS)
            3'b000: taken = 1'b0;
            3'b001: taken = SC_MICROSEQ_Flags_InBUS[3];
            3'b010: taken = SC_MICROSEQ_Flags_InBUS[2];
            3'b011: taken = SC_MICROSEQ_Flags_InBUS[1];
            3'b100: taken = SC_MICROSEQ_Flags_InBUS[0];
            3'b101: taken = SC_MICROSEQ_IR_InBUS[13];
            3'b110: taken = 1'b1;
            3'b111: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_addr = incr_addr;
        if (SC_MICROSEQ_Cond_InBUS == 3'b111) begin
            next_addr = decode_addr;
        end else if (taken) begin
            next_addr = SC_MICROSEQ_JumpAddr_InBUS;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        csai_d  = csai_q;
        stall_d = stall_q;
        case (state_q)
            ST_BOOT: begin
                // Address 0 stays up one extra cycle so the MIR fills.
                state_d = ST_RUN;
                csai_d  = 11'd0;
                stall_d = 1'b0;
            end
            ST_RUN: begin
                if (stall_cond) begin
                    state_d = ST_WAIT;
                    stall_d = 1'b1;
                end else begin
                    csai_d  = next_addr;
                    stall_d = 1'b0;
                end
            end
            ST_WAIT: begin
`ifdef SC_MICROSEQ_MEMWAIT_EN
                if (SC_MICROSEQ_MemReady_In) begin
                    state_d = ST_RUN;
                    csai_d  = next_addr;
                    stall_d = 1'b0;
                end
`else
                // Unreachable in this build; recover cleanly.
                state_d = ST_BOOT;
                csai_d  = 11'd0;
                stall_d = 1'b0;
`endif
            end
            default: begin
                state_d = ST_BOOT;
                csai_d  = 11'd0;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SC_MICROSEQ_CLOCK_50) begin
        if (!SC_MICROSEQ_RESET_InLow) begin
            state_q <= ST_BOOT;
            csai_q  <= 11'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            csai_q  <= csai_d;
            stall_q <= stall_d;
        end
    end

    assign SC_MICROSEQ_CSAddr_OutBUS = csai_q;
    assign SC_MICROSEQ_Stall_Out     = stall_q;
    assign SC_MICROSEQ_State_OutBUS  = state_q;

endmodule

// File: tb/tb_sc_microseq.sv
// tb_sc_microseq: vector table, corner sequences and randomized run
// against a behavioural sequencer model.
module tb_sc_microseq;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic [3:0]  flags;
    logic [31:0] ir;
    logic        rd;
    logic        wr;
    logic        rdy;
    logic [10:0] addr;
    logic        stall;
    logic [1:0]  state;

    int n_tests;
    int n_fail;

`ifdef SC_MICROSEQ_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    sc_microseq dut (
        .SC_MICROSEQ_CLOCK_50      (clk),
        .SC_MICROSEQ_RESET_InLow   (rst_n),
        .SC_MICROSEQ_Cond_InBUS    (cond),
        .SC_MICROSEQ_JumpAddr_InBUS(jump),
        .SC_MICROSEQ_Flags_InBUS   (flags),
        .SC_MICROSEQ_IR_InBUS      (ir),
        .SC_MICROSEQ_Read_In       (rd),
        .SC_MICROSEQ_Write_In      (wr),
        .SC_MICROSEQ_MemReady_In   (rdy),
        .SC_MICROSEQ_CSAddr_OutBUS (addr),
        .SC_MICROSEQ_Stall_Out     (stall),
        .SC_MICROSEQ_State_OutBUS  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          start;
        logic [2:0]  cond;
        logic [10:0] jump;
        logic [3:0]  flags;
        logic [31:0] ir;
        int          exp;
    } vec_t;

    vec_t vt[14];

    // Model state: 0=BOOT 1=RUN 2=WAIT
    int m_addr;
    int m_stall;
    int m_state;

    function automatic int model_n(int a, int c, int j,
                                   logic [3:0] f, logic [31:0] i);
        bit t;
        t = 1'b0;
        case (c)
            0: t = 1'b0;
            1: t = f[3];
            2: t = f[2];
            3: t = f[1];
            4: t = f[0];
            5: t = i[13];
            6: t = 1'b1;
            default: return 1024 + int'(i[31:30]) * 256
                            + int'(i[24:19]) * 4;
        endcase
        return t ? j : (a + 1) % 2048;
    endfunction

    // Advance the model by one edge using the current inputs.
    task automatic model_edge();
        int n;
        n = model_n(m_addr, int'(cond), int'(jump), flags, ir);
        if (!rst_n) begin
            m_state = 0; m_addr = 0; m_stall = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_addr = 0; m_stall = 0;
        end else if (m_state == 1) begin
            if (MEMWAIT && (rd || wr) && !rdy) begin
                m_state = 2; m_stall = 1;
            end else begin
                m_addr = n; m_stall = 0;
            end
        end else begin
            if (rdy) begin
                m_state = 1; m_addr = n; m_stall = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk3(string name, int a, int s, int st);
        chk({name, " addr"}, int'(addr), a);
        chk({name, " stall"}, int'(stall), s);
        chk({name, " state"}, int'(state), st);
    endtask

    task automatic goto_addr(int a);
        cond = 3'b110; jump = 11'(a);
        rd = 1'b0; wr = 1'b0; rdy = 1'b0;
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; cond = 3'b000; jump = '0; flags = '0;
        ir = '0; rd = 1'b0; wr = 1'b0; rdy = 1'b0;

        vt[0]  = '{5,    3'b010, 11'h400, 4'b0100, 32'h0, 'h400};
        vt[1]  = '{5,    3'b010, 11'h400, 4'b0000, 32'h0, 6};
        vt[2]  = '{3,    3'b111, 11'h000, 4'b0000, 32'h8200_0000, 'h600};
        vt[3]  = '{3,    3'b111, 11'h000, 4'b0000, 32'hC000_0000, 'h700};
        vt[4]  = '{2047, 3'b000, 11'h000, 4'b0000, 32'h0, 0};
        vt[5]  = '{2047, 3'b110, 11'h7FF, 4'b0000, 32'h0, 2047};
        vt[6]  = '{10,   3'b001, 11'h123, 4'b1000, 32'h0, 'h123};
        vt[7]  = '{10,   3'b001, 11'h123, 4'b0111, 32'h0, 11};
        vt[8]  = '{20,   3'b011, 11'h055, 4'b0010, 32'h0, 'h55};
        vt[9]  = '{20,   3'b100, 11'h2AA, 4'b0001, 32'h0, 'h2AA};
        vt[10] = '{20,   3'b100, 11'h2AA, 4'b1110, 32'h0, 21};
        vt[11] = '{30,   3'b101, 11'h700, 4'b0000, 32'h0000_2000, 'h700};
        vt[12] = '{30,   3'b101, 11'h700, 4'b1111, 32'hFFFF_DFFF, 31};
        vt[13] = '{100,  3'b000, 11'h7FF, 4'b1111, 32'h0, 101};

        // Reset and boot sequence 0,0,1,2,3
        step();
        step();
        chk3("reset", 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk3("boot edge", 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("count", int'(addr), k);
        end

        // Vector table
        for (int v = 0; v < 14; v++) begin
            goto_addr(vt[v].start);
            chk($sformatf("vec%0d setup", v), int'(addr), vt[v].start);
            cond = vt[v].cond; jump = vt[v].jump;
            flags = vt[v].flags; ir = vt[v].ir;
            step();
            chk($sformatf("vec%0d next", v), int'(addr), vt[v].exp);
        end

`ifdef SC_MICROSEQ_MEMWAIT_EN
        // Read wait: 3 cycles held then advance
        goto_addr(9);
        cond = 3'b000; rd = 1'b1; rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk3("wait hold", 9, 1, 2);
        end
        rdy = 1'b1;
        step();
        chk3("wait done", 10, 0, 1);

        // Read and write together take a single wait
        goto_addr(40);
        cond = 3'b000; rd = 1'b1; wr = 1'b1; rdy = 1'b0;
        step();
        chk3("rw wait", 40, 1, 2);
        rdy = 1'b1;
        step();
        chk3("rw done", 41, 0, 1);
        step();
        chk3("rw no rewait", 42, 0, 1);

        // Reset in WAIT abandons the access
        goto_addr(50);
        cond = 3'b000; rd = 1'b1; wr = 1'b0; rdy = 1'b0;
        step();
        chk3("pre reset wait", 50, 1, 2);
        rst_n = 1'b0; rdy = 1'b1;
        step();
        chk3("reset in wait", 0, 0, 0);
        rst_n = 1'b1; rd = 1'b0; rdy = 1'b0;
        step();
        chk3("reboot", 0, 0, 1);
`else
        // Single-cycle memory: access never stalls
        goto_addr(9);
        cond = 3'b000; rd = 1'b1; rdy = 1'b0;
        step();
        chk3("no wait", 10, 0, 1);
        wr = 1'b1;
        step();
        chk3("no wait rw", 11, 0, 1);
`endif

        // Randomized run against model
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0;
        step();
        m_state = 0; m_addr = 0; m_stall = 0;
        chk3("rand reset", 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            cond  = 3'($urandom_range(0, 7));
            jump  = 11'($urandom);
            flags = 4'($urandom);
            ir    = $urandom;
            rd    = ($urandom_range(0, 3) == 0);
            wr    = ($urandom_range(0, 5) == 0);
            rdy   = ($urandom_range(0, 2) == 0);
            model_edge();
            step();
            chk3($sformatf("rand%0d", k), m_addr, m_stall, m_state);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
